// File: rtl/i2s_sample_rx_if.sv
// Sample-stream bundle between the I2S receiver and its consumers.
// The master side generates the I2S bit/word clocks and publishes vld/lft_chnnl/rght_chnnl.
interface i2s_sample_rx_if;
   localparam int unsigned SMP_W = 16;

   logic             I2S_data;
   logic             I2S_sclk;
   logic             I2S_ws;
   logic             vld;
   logic [SMP_W-1:0] lft_chnnl;
   logic [SMP_W-1:0] rght_chnnl;

   modport master (
      input  I2S_data,
      output I2S_sclk,
      output I2S_ws,
      output vld,
      output lft_chnnl,
      output rght_chnnl
   );

   modport slave (
      output I2S_data,
      input  I2S_sclk,
      input  I2S_ws,
      input  vld,
      input  lft_chnnl,
      input  rght_chnnl
   );
endinterface

// File: rtl/i2s_sample_rx.sv
// I2S master receiver: divides clk into sclk/ws, deserializes 16-bit L/R samples, one vld per frame.
// Optional build macro I2S_RX_STARTUP_MUTE_EN suppresses the first two frames after reset.
module i2s_sample_rx #(
   parameter int unsigned SCLK_DIV = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   i2s_sample_rx_if.master bus
);

   localparam int unsigned CNT_W = $clog2(SCLK_DIV);
   localparam int unsigned BIT_W = 6;
   localparam int unsigned SLOT_W = 5;
   localparam int unsigned SMP_W = 16;

   localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(SCLK_DIV - 1);
   localparam logic [CNT_W-1:0]  CNT_RISE_M1 = CNT_W'(SCLK_DIV / 2 - 1);
   localparam logic [SLOT_W-1:0] B_FIRST     = SLOT_W'(1);
   localparam logic [SLOT_W-1:0] B_LAST      = SLOT_W'(SMP_W);

   typedef enum logic [0:0] {
      ST_COLLECT = 1'b0,
      ST_PUBLISH = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   clk_cnt_q, clk_cnt_d;
   logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [SMP_W-1:0]   shift_q, shift_d;
   logic [SMP_W-1:0]   shadow_q, shadow_d;
   logic [SMP_W-1:0]   lft_q, lft_d;
   logic [SMP_W-1:0]   rght_q, rght_d;
   logic               vld_q, vld_d;

   logic               sclk_fall_c;
   logic               sclk_rise_c;
   logic [SLOT_W-1:0]  slot_b_c;
   logic               right_c;
   logic               take_bit_c;
   logic               last_bit_c;
   logic [SMP_W-1:0]   shift_nxt_c;
   logic               pub_ok_c;

`ifdef I2S_RX_STARTUP_MUTE_EN
   localparam logic [1:0] MUTE_FRAMES = 2'd2;
   logic [1:0] mute_cnt_q, mute_cnt_d;
   assign pub_ok_c = (mute_cnt_q == MUTE_FRAMES);
`else
   assign pub_ok_c = 1'b1;
`endif

   // Edge qualifiers: these fire on the clk edge that moves sclk low/high.
   assign sclk_fall_c = (clk_cnt_q == CNT_LAST);
   assign sclk_rise_c = (clk_cnt_q == CNT_RISE_M1);
   assign slot_b_c    = bit_cnt_q[SLOT_W-1:0];
   assign right_c     = bit_cnt_q[BIT_W-1];
   assign take_bit_c  = sclk_rise_c && (slot_b_c >= B_FIRST) && (slot_b_c <= B_LAST);
   assign last_bit_c  = sclk_rise_c && (slot_b_c == B_LAST);
   // Codec launches on sclk fall, so sampling at sclk rise gives half a period of margin.
   assign shift_nxt_c = {shift_q[SMP_W-2:0], bus.I2S_data};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_COLLECT;
         clk_cnt_q <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         shadow_q  <= '0;
         lft_q     <= '0;
         rght_q    <= '0;
         vld_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         clk_cnt_q <= clk_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         shadow_q  <= shadow_d;
         lft_q     <= lft_d;
         rght_q    <= rght_d;
         vld_q     <= vld_d;
      end
   end

`ifdef I2S_RX_STARTUP_MUTE_EN
   // Saturating count of completed frames; only reset clears it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mute_cnt_q <= '0;
      end else begin
         mute_cnt_q <= mute_cnt_d;
      end
   end
`endif

   always_comb begin
      state_d   = state_q;
      clk_cnt_d = clk_cnt_q + CNT_W'(1);
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      shadow_d  = shadow_q;
      lft_d     = lft_q;
      rght_d    = rght_q;
      vld_d     = 1'b0;
`ifdef I2S_RX_STARTUP_MUTE_EN
      mute_cnt_d = mute_cnt_q;
`endif

      if (sclk_fall_c) begin
         bit_cnt_d = bit_cnt_q + BIT_W'(1);
      end
      if (take_bit_c) begin
         shift_d = shift_nxt_c;
      end
      // Left word is parked so both channels can be published on one edge.
      if (last_bit_c && !right_c) begin
         shadow_d = shift_nxt_c;
      end

      case (state_q)
         ST_COLLECT: begin
            if (last_bit_c && right_c) begin
               state_d = ST_PUBLISH;
            end
         end
         ST_PUBLISH: begin
            state_d = ST_COLLECT;
            if (pub_ok_c) begin
               lft_d  = shadow_q;
               rght_d = shift_q;
               vld_d  = 1'b1;
            end
`ifdef I2S_RX_STARTUP_MUTE_EN
            else begin
               mute_cnt_d = mute_cnt_q + 2'd1;
            end
`endif
         end
         default: state_d = ST_COLLECT;
      endcase
   end

   assign bus.I2S_sclk   = clk_cnt_q[CNT_W-1];
   assign bus.I2S_ws     = bit_cnt_q[BIT_W-1];
   assign bus.vld        = vld_q;
   assign bus.lft_chnnl  = lft_q;
   assign bus.rght_chnnl = rght_q;

endmodule

// File: tb/tb_i2s_sample_rx.sv
// Bench for i2s_sample_rx: codec model driven from its own edge count, cycle-by-cycle output model.
module tb_i2s_sample_rx;

   localparam int SCLK_DIV  = 16;
   localparam int FIRST_VLD = 777;
   localparam int FRAME     = 1024;
   localparam int NF        = 6;
`ifdef I2S_RX_STARTUP_MUTE_EN
   localparam int MUTE_FRAMES = 2;
`else
   localparam int MUTE_FRAMES = 0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   i2s_sample_rx_if bus();

   i2s_sample_rx #(.SCLK_DIV(SCLK_DIV)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [15:0] lft_tx [NF] = '{16'h1234, 16'h8000, 16'hFFFF, 16'h5555, 16'h0000, 16'h7FFF};
   logic [15:0] rgt_tx [NF] = '{16'hABCD, 16'h7FFF, 16'h0001, 16'hAAAA, 16'hFFFF, 16'h8000};

   int          n_cmp   = 0;
   int          n_mis   = 0;
   int          edge_n  = 0;
   int          vld_cnt = 0;
   logic [15:0] exp_l   = '0;
   logic [15:0] exp_r   = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h, want %h (edge %0d)", tag, obs, exp, edge_n);
      end
   endtask

   // Codec: delay bit opposite to MSB, 16 data bits, trailing bits all-ones in frame 0 else random.
   function automatic logic codec_bit(input int slot);
      int          f;
      int          b;
      logic        right;
      logic [15:0] w;
      f     = (slot / 64) % NF;
      b     = slot % 32;
      right = (slot % 64) >= 32;
      w     = right ? rgt_tx[f] : lft_tx[f];
      if (b == 0)       return ~w[15];
      else if (b <= 16) return w[16 - b];
      else if (f == 0)  return 1'b1;
      else              return 1'($urandom_range(0, 1));
   endfunction

   // Per-edge model of every output, plus codec launch after each edge.
   initial begin
      bit ev;
      forever begin
         @(posedge clk);
         #1;
         ev = 1'b0;
         if (!rst_n) begin
            edge_n = 0;
            exp_l  = '0;
            exp_r  = '0;
         end else begin
            edge_n++;
            if (edge_n >= FIRST_VLD && ((edge_n - FIRST_VLD) % FRAME) == 0 &&
                ((edge_n - FIRST_VLD) / FRAME) >= MUTE_FRAMES) begin
               ev    = 1'b1;
               exp_l = lft_tx[((edge_n - FIRST_VLD) / FRAME) % NF];
               exp_r = rgt_tx[((edge_n - FIRST_VLD) / FRAME) % NF];
            end
         end
         if (bus.vld === 1'b1) vld_cnt++;
         chk("sclk", 32'(bus.I2S_sclk), 32'(rst_n && (edge_n % SCLK_DIV) >= SCLK_DIV / 2));
         chk("ws",   32'(bus.I2S_ws),   32'(rst_n && (edge_n % FRAME) >= FRAME / 2));
         chk("vld",  32'(bus.vld),      32'(ev));
         chk("lft",  32'(bus.lft_chnnl),  32'(exp_l));
         chk("rght", 32'(bus.rght_chnnl), 32'(exp_r));
         bus.I2S_data = codec_bit(edge_n / SCLK_DIV);
      end
   end

   task automatic run_to(input int target);
      for (int i = 0; i < 20000 && edge_n < target; i++) @(negedge clk);
      chk("run_reached", 32'(edge_n >= target), 32'd1);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_sclk"}, 32'(bus.I2S_sclk),   32'd0);
      chk({tag, "_ws"},   32'(bus.I2S_ws),     32'd0);
      chk({tag, "_vld"},  32'(bus.vld),        32'd0);
      chk({tag, "_lft"},  32'(bus.lft_chnnl),  32'd0);
      chk({tag, "_rght"}, 32'(bus.rght_chnnl), 32'd0);
   endtask

   initial begin
      bus.I2S_data = 1'b0;
      rst_n        = 1'b0;
      repeat (3) @(negedge clk);
      chk_zero("reset");

      // Six frames of directed words, bit-exact extremes included.
      rst_n   = 1'b1;
      vld_cnt = 0;
      run_to(6000);
      chk("run1_vld_count", 32'(vld_cnt), 32'(NF - MUTE_FRAMES));

      // Async reset while outputs hold data.
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_zero("async_rst");
      repeat (3) @(negedge clk);
      rst_n   = 1'b1;
      vld_cnt = 0;

      // Reset at edge 1624: mid right slot of frame 1, which must never be published.
      run_to(1624);
      chk("run2_vld_count", 32'(vld_cnt), 32'(MUTE_FRAMES == 0 ? 1 : 0));
      rst_n = 1'b0;
      #1;
      chk_zero("midframe_rst");
      repeat (3) @(negedge clk);
      rst_n   = 1'b1;
      vld_cnt = 0;
      run_to(2900);
      chk("run3_vld_count", 32'(vld_cnt), 32'(3 - MUTE_FRAMES));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/i2s_sample_rx.md
# i2s_sample_rx

I2S master receiver that produces the audio sample stream for the equalizer/LED datapath. Generates `I2S_sclk` and `I2S_ws` from the system clock and deserializes the codec ADC line `I2S_data`. Presents one left/right pair of signed 16-bit samples per frame with a single-cycle `vld` strobe. This is the producer side of the `vld`/`lft_chnnl`/`rght_chnnl` interface consumed by the LED driver and filter banks.

## Interface
- `SCLK_DIV`, 16, `clk` cycles per `I2S_sclk` period; power of 2, ≥4.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `I2S_data`  in  1  serial ADC data from codec, MSB first.
- `I2S_sclk`  out  1  bit clock to codec.
- `I2S_ws`  out  1  word select: 0 = left slot, 1 = right slot.
- `vld`  out  1  one-cycle strobe; new sample pair on outputs.
- `lft_chnnl`  out  16  signed left sample, held between strobes.
- `rght_chnnl`  out  16  signed right sample, held between strobes.

## Operation
- Clock divider:
  - `clk_cnt` is log2(`SCLK_DIV`) bits, free-running, reset 0.
  - `I2S_sclk` = MSB of `clk_cnt` (registered).
  - Low for the first `SCLK_DIV`/2 clks after reset, then high for `SCLK_DIV`/2.
- Frame counter:
  - `bit_cnt` is 6 bits (0..63), reset 0.
  - Increments on the `clk` edge where `clk_cnt` wraps to 0 (sclk falling edge).
  - Wraps 63→0.
  - `I2S_ws` = `bit_cnt[5]`: slot 0–31 left, 32–63 right.
- Sampling:
  - `I2S_data` is sampled on the `clk` edge where `clk_cnt` becomes `SCLK_DIV`/2 (sclk rising edge).
  - Slot bit index b = `bit_cnt[4:0]`.
  - b=0 is the I2S one-bit delay and is ignored.
  - b=1..16 are shifted in MSB first.
  - b=17..31 are ignored.
- Buffering:
  - After left b=16 is sampled, the 16-bit shift register is copied to a left shadow register.
  - After right b=16 is sampled, then on the next `clk` edge: `lft_chnnl` ← shadow, `rght_chnnl` ← shift register, and `vld` is asserted for exactly one cycle.
  - Both outputs always update on the same edge; a left sample is never paired with a stale right sample.
- Arithmetic: none. Bits pass through unmodified as two's complement; 16'h8000 and 16'h7FFF must be delivered unchanged.
- Reset values: `I2S_sclk`=0, `I2S_ws`=0, `vld`=0, `lft_chnnl`=0, `rght_chnnl`=0. All counters, the shift register and the shadow register are 0.
- Reset mid-frame:
  - Any partial frame is discarded.
  - Outputs return to 0 asynchronously.
  - Framing restarts at left slot b=0; no `vld` occurs for the discarded frame.
- No backpressure. Consumers must accept `vld` whenever it is asserted.

## Timing
- Edges are numbered n=1,2,… after `rst_n` deassertion; default `SCLK_DIV`=16.
- `clk_cnt` after edge n = n mod 16. `I2S_sclk` is high after edges where (n mod 16) ≥ 8.
- Left bit b is sampled at edge 16b+8.
- Right bit b is sampled at edge 16(32+b)+8, so right b=16 is sampled at edge 776.
- First `vld` is high after edge 777 and low after edge 778. The outputs become valid at edge 777.
- Steady state: one `vld` per 1024 clks, i.e. frame = 64 sclk. Sample rate = f_clk/1024.
- `I2S_ws` toggles only on sclk falling edges:
  - high after edge 512
  - low after edge 1024
- Codec data must be stable around sclk rising edges. The codec launches data on falling edges, giving a half-period setup margin.

## Configuration
- `I2S_RX_STARTUP_MUTE_EN`
  - Defined: `vld` is suppressed for the first 2 complete frames after reset, and `lft_chnnl`/`rght_chnnl` stay 0 during that time. This covers codec ADC settling. The first `vld` is after edge 777+2048=2825. A 2-bit frame counter saturates at 2 and is cleared only by reset.
  - Undefined: first `vld` after edge 777, as described in Timing.
  - `I2S_sclk`/`I2S_ws` behaviour is identical in both builds.

## Test plan
- Codec model sends left=16'h1234, right=16'hABCD with slot bits 17–31 = 1 → `vld` pulses once after edge 777 with `lft_chnnl`=1234, `rght_chnnl`=ABCD. Outputs hold until the next `vld` at edge 1801.
- Left=16'h8000, right=16'h7FFF, then the next frame 16'hFFFF/16'h0001 → delivered bit-exact on consecutive `vld` strobes 1024 clks apart.
- Free-run 4 frames → `I2S_sclk` period 16 clks at 50% duty, `I2S_ws` period 1024 clks and toggling only when `I2S_sclk` falls, exactly 4 single-cycle `vld` pulses.
- Delay bit b=0 driven opposite to the MSB and trailing bits randomized → outputs unaffected.
- Assert `rst_n` at edge 600 (mid right slot), release after 3 clks → all outputs 0 immediately, no `vld` from the interrupted frame, next `vld` 777 edges after release.
- Build with `I2S_RX_STARTUP_MUTE_EN` defined, sending 16'h5555/16'hAAAA every frame → no `vld` before edge 2825, then `vld` with 5555/AAAA every 1024 clks.
